// File: rtl/stream_ram_server_if.sv
// Stream handshake bundle for stream_ram_server.
// Carries three inbound word streams (address, write-enable, write-data) and one
// outbound response stream. Each stream is a stb/ack pair plus its payload.
// The slave modport is the RAM server side. The master modport is the initiator side.
interface stream_ram_server_if #(
  parameter int DATA_WIDTH = 32
);
  logic [31:0]           input_address;
  logic                  input_address_stb;
  logic                  input_address_ack;
  logic [31:0]           input_we;
  logic                  input_we_stb;
  logic                  input_we_ack;
  logic [DATA_WIDTH-1:0] input_data_in;
  logic                  input_data_in_stb;
  logic                  input_data_in_ack;
  logic [DATA_WIDTH-1:0] output_data_out;
  logic                  output_data_out_stb;
  logic                  output_data_out_ack;

  modport slave (
    input  input_address, input_address_stb, output input_address_ack,
    input  input_we,      input_we_stb,      output input_we_ack,
    input  input_data_in, input_data_in_stb, output input_data_in_ack,
    output output_data_out, output output_data_out_stb, input output_data_out_ack
  );

  modport master (
    output input_address, output input_address_stb, input input_address_ack,
    output input_we,      output input_we_stb,      input input_we_ack,
    output input_data_in, output input_data_in_stb, input input_data_in_ack,
    input  output_data_out, input output_data_out_stb, output output_data_out_ack
  );
endinterface

// File: rtl/stream_ram_server.sv
// Stream-handshake responder around a single-port, read-first RAM.
// Each transaction arrives as three words: address, write-enable and write-data.
// The block then does one RAM access and returns the pre-access word.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset. Clears the FSM and outputs, but not the RAM.
//   bus  stream_ram_server_if.slave, which carries the three inbound streams and the response.
module stream_ram_server #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  stream_ram_server_if.slave bus
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  typedef enum logic [2:0] {
    GET_ADDR = 3'd0,
    GET_WE   = 3'd1,
    GET_DATA = 3'd2,
    ACCESS   = 3'd3,
    PUT      = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic                     addr_ack_q, we_ack_q, data_ack_q, out_stb_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic                     we_q;
  logic [DATA_WIDTH-1:0]    data_q;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic [DATA_WIDTH-1:0]    mem_q [DEPTH];

  logic addr_xfer_s, we_xfer_s, data_xfer_s, out_xfer_s;

  // Address bits above the RAM index and we bits 31:1 are don't-care by design.
  logic unused_ok;
  assign unused_ok = ^{bus.input_address[31:ADDRESS_WIDTH], bus.input_we[31:1]};

  // Each ack/stb is a register, so it can only be high in its own state.
  // That register also qualifies the transfer.
  assign addr_xfer_s = addr_ack_q & bus.input_address_stb;
  assign we_xfer_s   = we_ack_q   & bus.input_we_stb;
  assign data_xfer_s = data_ack_q & bus.input_data_in_stb;
  assign out_xfer_s  = out_stb_q  & bus.output_data_out_ack;

  assign bus.input_address_ack   = addr_ack_q;
  assign bus.input_we_ack        = we_ack_q;
  assign bus.input_data_in_ack   = data_ack_q;
  assign bus.output_data_out_stb = out_stb_q;
  assign bus.output_data_out     = rdata_q;

  // Next-state logic: advance one step per completed handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      GET_ADDR: if (addr_xfer_s) state_d = GET_WE;   else state_d = state_q;
      GET_WE:   if (we_xfer_s)   state_d = GET_DATA; else state_d = state_q;
      GET_DATA: if (data_xfer_s) state_d = ACCESS;   else state_d = state_q;
      ACCESS:   state_d = PUT;
      PUT:      if (out_xfer_s)  state_d = GET_ADDR; else state_d = state_q;
      default:  state_d = GET_ADDR;
    endcase
  end

  // State register, registered Moore handshake outputs, transaction latches and read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= GET_ADDR;
      addr_ack_q <= 1'b0;
      we_ack_q   <= 1'b0;
      data_ack_q <= 1'b0;
      out_stb_q  <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      data_q     <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      // Decoding state_d keeps each flag aligned with the state it belongs to.
      addr_ack_q <= (state_d == GET_ADDR);
      we_ack_q   <= (state_d == GET_WE);
      data_ack_q <= (state_d == GET_DATA);
      out_stb_q  <= (state_d == PUT);
      if (addr_xfer_s) addr_q <= bus.input_address[ADDRESS_WIDTH-1:0];
      if (we_xfer_s)   we_q   <= bus.input_we[0];
      if (data_xfer_s) data_q <= bus.input_data_in;
      // rdata_q changes only here, so the response stays stable throughout PUT.
      if (state_q == ACCESS) rdata_q <= mem_q[addr_q];
    end
  end

  // RAM write port.
  // The nonblocking update lets the read above see the old word, which gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == ACCESS) && we_q) begin
      mem_q[addr_q] <= data_q;
    end
  end

endmodule
